// File: rtl/comparator_4bit_sync.sv
// Registered 4-bit magnitude comparator with 74x85-style cascade inputs.
// One cycle of latency; results hold while in_valid is low.
module comparator_4bit_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_valid,
  input  logic       signed_mode,
  input  logic       gt_in,
  input  logic       lt_in,
  input  logic       eq_in,
  output logic       greater,
  output logic       less,
  output logic       equal,
  output logic [3:0] diff,
  output logic       out_valid
);

  logic [4:0] a_ext, b_ext, sub5, mag5;
  logic       loc_gt, loc_lt, loc_eq;
  logic       greater_d, less_d, equal_d;
  logic       greater_q, less_q, equal_q, out_valid_q;
  logic [3:0] diff_d, diff_q;

  // Sign-extend only in signed mode so one 5-bit signed compare covers both modes.
  always_comb begin
    a_ext  = {signed_mode & a[3], a};
    b_ext  = {signed_mode & b[3], b};
    sub5   = a_ext - b_ext;
    mag5   = sub5[4] ? (5'd0 - sub5) : sub5;
    diff_d = mag5[3:0];
    loc_eq = (a == b);
    loc_lt = $signed(a_ext) < $signed(b_ext);
    loc_gt = !loc_eq && !loc_lt;
  end

  // Cascade inputs decide only on a local tie, priority gt > lt > eq.
  always_comb begin
    greater_d = 1'b0;
    less_d    = 1'b0;
    equal_d   = 1'b0;
    if (!loc_eq) begin
      greater_d = loc_gt;
      less_d    = loc_lt;
    end else if (gt_in) begin
      greater_d = 1'b1;
    end else if (lt_in) begin
      less_d = 1'b1;
    end else begin
      equal_d = 1'b1;
    end
  end

  // eq_in is implied by the absence of gt_in/lt_in; the all-zero case resolves to equal.
  logic unused_eq_in;
  assign unused_eq_in = eq_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      greater_q   <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      diff_q      <= 4'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        greater_q <= greater_d;
        less_q    <= less_d;
        equal_q   <= equal_d;
        diff_q    <= diff_d;
      end
    end
  end

  assign greater   = greater_q;
  assign less      = less_q;
  assign equal     = equal_q;
  assign diff      = diff_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_comparator_4bit_sync.sv
// Directed and exhaustive self-checking bench for comparator_4bit_sync.
module tb_comparator_4bit_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a, b;
  logic       in_valid, signed_mode, gt_in, lt_in, eq_in;
  logic       greater, less, equal, out_valid;
  logic [3:0] diff;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comparator_4bit_sync dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .in_valid    (in_valid),
    .signed_mode (signed_mode),
    .gt_in       (gt_in),
    .lt_in       (lt_in),
    .eq_in       (eq_in),
    .greater     (greater),
    .less        (less),
    .equal       (equal),
    .diff        (diff),
    .out_valid   (out_valid)
  );

  // Packed observation: {greater, less, equal, diff[3:0], out_valid}
  function automatic logic [7:0] obs();
    return {greater, less, equal, diff, out_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0;
    a = 4'd0; b = 4'd0; gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1;
    tick();
    tick();
    checks++;
    if (obs() !== 8'b000_0000_0) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", obs(), 8'b000_0000_0);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    logic [3:0] ta [5] = '{4'd1, 4'd10, 4'd6, 4'd15, 4'd0};
    logic [3:0] tb [5] = '{4'd2, 4'd5, 4'd6, 4'd0, 4'd15};
    logic [7:0] te [5] = '{8'b010_0001_1, 8'b100_0101_1, 8'b001_0000_1,
                           8'b100_1111_1, 8'b010_1111_1};
    signed_mode = 1'b0; gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = ta[i]; b = tb[i]; in_valid = 1'b1;
      tick();
      checks++;
      if (obs() !== te[i]) begin
        errors++;
        $display("FAIL unsigned_%0d (%0d vs %0d): got %b required %b",
                 i, ta[i], tb[i], obs(), te[i]);
      end
    end
  endtask

  task automatic test_signed();
    logic [3:0] ta [3] = '{4'b1111, 4'b0111, 4'b1010};
    logic [3:0] tb [3] = '{4'b0000, 4'b1000, 4'b0101};
    logic [7:0] te [3] = '{8'b010_0001_1, 8'b100_1111_1, 8'b010_1011_1};
    signed_mode = 1'b1; gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = ta[i]; b = tb[i]; in_valid = 1'b1;
      tick();
      checks++;
      if (obs() !== te[i]) begin
        errors++;
        $display("FAIL signed_%0d (%b vs %b): got %b required %b",
                 i, ta[i], tb[i], obs(), te[i]);
      end
    end
    signed_mode = 1'b0;
  endtask

  task automatic test_cascade();
    logic [3:0] ta  [4] = '{4'd3, 4'd3, 4'd3, 4'd2};
    logic [2:0] cas [4] = '{3'b100, 3'b010, 3'b000, 3'b101}; // {gt_in, lt_in, eq_in}
    logic [7:0] te  [4] = '{8'b100_0000_1, 8'b010_0000_1, 8'b001_0000_1, 8'b010_0001_1};
    signed_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = ta[i]; b = 4'd3; {gt_in, lt_in, eq_in} = cas[i]; in_valid = 1'b1;
      tick();
      checks++;
      if (obs() !== te[i]) begin
        errors++;
        $display("FAIL cascade_%0d: got %b required %b", i, obs(), te[i]);
      end
    end
    gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1;
  endtask

  task automatic test_hold();
    signed_mode = 1'b0;
    a = 4'd9; b = 4'd4; in_valid = 1'b1;
    tick();
    checks++;
    if (obs() !== 8'b100_0101_1) begin
      errors++;
      $display("FAIL hold_capture: got %b required %b", obs(), 8'b100_0101_1);
    end
    a = 4'd0; b = 4'd15; in_valid = 1'b0;
    tick();
    checks++;
    if (obs() !== 8'b100_0101_0) begin
      errors++;
      $display("FAIL hold_idle1: got %b required %b", obs(), 8'b100_0101_0);
    end
    tick();
    checks++;
    if (obs() !== 8'b100_0101_0) begin
      errors++;
      $display("FAIL hold_idle2: got %b required %b", obs(), 8'b100_0101_0);
    end
  endtask

  task automatic test_reset_midstream();
    signed_mode = 1'b0;
    a = 4'd2; b = 4'd1; in_valid = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (obs() !== 8'b000_0000_0) begin
      errors++;
      $display("FAIL reset_over_valid: got %b required %b", obs(), 8'b000_0000_0);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== 8'b100_0001_1) begin
      errors++;
      $display("FAIL post_reset_capture: got %b required %b", obs(), 8'b100_0001_1);
    end
  endtask

  task automatic test_sweep();
    int va, vb, d;
    logic [7:0] exp_v;
    gt_in = 1'b0; lt_in = 1'b0; eq_in = 1'b1; in_valid = 1'b1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          signed_mode = m[0]; a = i[3:0]; b = j[3:0];
          va = (m == 1 && i >= 8) ? i - 16 : i;
          vb = (m == 1 && j >= 8) ? j - 16 : j;
          d  = (va > vb) ? va - vb : vb - va;
          exp_v = {va > vb, va < vb, va == vb, d[3:0], 1'b1};
          tick();
          checks++;
          if (obs() !== exp_v) begin
            errors++;
            $display("FAIL sweep mode=%0d a=%0d b=%0d: got %b required %b",
                     m, i, j, obs(), exp_v);
          end
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_cascade();
    test_hold();
    test_reset_midstream();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
